// File: rtl/ibex_regfile_cache_pkg.sv
// Shared types for the register-file L1 cache: FSM states and refill target.
package ibex_regfile_cache_pkg;

  typedef enum logic {
    RFC_IDLE,
    RFC_FILL
  } rfc_state_e;

  typedef enum logic {
    RFC_TGT_A,
    RFC_TGT_B
  } rfc_target_e;

  // Tag width of the full RV32I register index; RV32E uses the low 4 bits.
  localparam int unsigned RFC_MAX_ADDR_W = 5;
  localparam int unsigned RFC_CNT_W      = 16;

endpackage

// File: rtl/ibex_regfile_cache_if.sv
// Single-port register SRAM bus between the register cache (master) and the backing SRAM.
interface ibex_regfile_cache_if #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 5
);
  logic                 req;
  logic                 we;
  logic [AddrWidth-1:0] addr;
  logic [DataWidth-1:0] wdata;
  logic [DataWidth-1:0] rdata;

  modport master (output req, we, addr, wdata, input rdata);
  modport slave  (input req, we, addr, wdata, output rdata);
endinterface

// File: rtl/ibex_regfile_cache_victim_sel.sv
// Victim picker: first invalid entry, otherwise round-robin from ptr_i skipping locked entries.
module ibex_regfile_cache_victim_sel
  import ibex_regfile_cache_pkg::*;
#(
  parameter  int unsigned NumEntries = 4,
  localparam int unsigned IdxW       = $clog2(NumEntries)
) (
  input  logic [NumEntries-1:0] valid_i,
  input  logic [NumEntries-1:0] lock_i,
  input  logic [IdxW-1:0]       ptr_i,
  output logic [IdxW-1:0]       victim_o
);

  function automatic logic [IdxW-1:0] rr_idx(input logic [IdxW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= int'(NumEntries)) s = s - int'(NumEntries);
    return IdxW'(s);
  endfunction

  logic found;

  always_comb begin
    victim_o = ptr_i;
    found    = 1'b0;
    for (int i = 0; i < NumEntries; i++) begin
      if (!found && !valid_i[i]) begin
        victim_o = IdxW'(i);
        found    = 1'b1;
      end
    end
    // Only one entry can be locked, so with two or more entries this always finds one.
    for (int k = 0; k < NumEntries; k++) begin
      if (!found && !lock_i[rr_idx(ptr_i, k)]) begin
        victim_o = rr_idx(ptr_i, k);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ibex_regfile_cache.sv
// Fully-associative L1 register cache in front of a single-port register SRAM (write-through).
module ibex_regfile_cache
  import ibex_regfile_cache_pkg::*;
#(
  parameter bit          RV32E           = 1'b0,
  parameter int unsigned DataWidth       = 32,
  parameter int unsigned NumCacheEntries = 4,
  parameter bit          EnablePerfCnt   = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_a_i,
  input  logic [4:0]           raddr_a_i,
  output logic [DataWidth-1:0] rdata_a_o,
  input  logic                 req_b_i,
  input  logic [4:0]           raddr_b_i,
  output logic [DataWidth-1:0] rdata_b_o,
  input  logic                 we_a_i,
  input  logic [4:0]           waddr_a_i,
  input  logic [DataWidth-1:0] wdata_a_i,
  output logic                 stall_o,
  ibex_regfile_cache_if.master sram,
  output logic [15:0]          perf_hit_o,
  output logic [15:0]          perf_miss_o
);

  localparam int unsigned AddrWidth = RV32E ? 4 : RFC_MAX_ADDR_W;
  localparam int unsigned IdxW      = $clog2(NumCacheEntries);

  typedef struct packed {
    logic                 valid;
    logic [AddrWidth-1:0] tag;
    logic [DataWidth-1:0] data;
  } rfc_entry_t;

  function automatic logic [RFC_CNT_W-1:0] sat_add(input logic [RFC_CNT_W-1:0] cnt,
                                                   input logic [1:0]           inc);
    logic [RFC_CNT_W:0] sum;
    sum = {1'b0, cnt} + {{(RFC_CNT_W-1){1'b0}}, inc};
    return sum[RFC_CNT_W] ? {RFC_CNT_W{1'b1}} : sum[RFC_CNT_W-1:0];
  endfunction

  logic [AddrWidth-1:0]       ra_a, ra_b, wa;
  logic                       unused_addr_bits;
  rfc_entry_t                 entries_q [NumCacheEntries];
  rfc_entry_t                 entries_d [NumCacheEntries];
  rfc_state_e                 state_q, state_d;
  rfc_target_e                fill_tgt;
  logic [IdxW-1:0]            ptr_q, ptr_d, fill_idx_q, fill_idx_d, victim;
  logic [AddrWidth-1:0]       fill_addr_q, fill_addr_d;
  logic [NumCacheEntries-1:0] valid_vec, hit_a_vec, hit_b_vec, wr_hit_vec, lock_mask;
  logic [DataWidth-1:0]       hit_a_data, hit_b_data;
  logic                       a_hit, b_hit, a_miss, b_miss, any_miss;
  logic                       write_pending, issue_fill, fill_wr_hit;

  assign ra_a             = raddr_a_i[AddrWidth-1:0];
  assign ra_b             = raddr_b_i[AddrWidth-1:0];
  assign wa               = waddr_a_i[AddrWidth-1:0];
  assign unused_addr_bits = ^{raddr_a_i, raddr_b_i, waddr_a_i};

  // Tag compare and hit muxes
  always_comb begin
    valid_vec  = '0;
    hit_a_vec  = '0;
    hit_b_vec  = '0;
    wr_hit_vec = '0;
    hit_a_data = '0;
    hit_b_data = '0;
    for (int i = 0; i < NumCacheEntries; i++) begin
      valid_vec[i]  = entries_q[i].valid;
      wr_hit_vec[i] = entries_q[i].valid && (entries_q[i].tag == wa);
      if (entries_q[i].valid && (entries_q[i].tag == ra_a)) begin
        hit_a_vec[i] = 1'b1;
        hit_a_data   = entries_q[i].data;
      end
      if (entries_q[i].valid && (entries_q[i].tag == ra_b)) begin
        hit_b_vec[i] = 1'b1;
        hit_b_data   = entries_q[i].data;
      end
    end
  end

  // x0 is never cached; no entry carries tag 0, so its data mux output is already zero.
  assign a_hit         = (ra_a == '0) || (|hit_a_vec);
  assign b_hit         = (ra_b == '0) || (|hit_b_vec);
  assign a_miss        = req_a_i && !a_hit;
  assign b_miss        = req_b_i && !b_hit;
  assign any_miss      = a_miss || b_miss;
  assign write_pending = we_a_i && (wa != '0);
  assign issue_fill    = !rst_i && (state_q == RFC_IDLE) && !write_pending && any_miss;
  assign fill_wr_hit   = write_pending && (wa == fill_addr_q);
  assign fill_tgt      = a_miss ? RFC_TGT_A : RFC_TGT_B;
  assign lock_mask     = (fill_tgt == RFC_TGT_A) ? (req_b_i ? hit_b_vec : '0)
                                                 : (req_a_i ? hit_a_vec : '0);

  assign rdata_a_o = rst_i ? '0 : hit_a_data;
  assign rdata_b_o = rst_i ? '0 : hit_b_data;

  ibex_regfile_cache_victim_sel #(
    .NumEntries (NumCacheEntries)
  ) u_victim_sel (
    .valid_i  (valid_vec),
    .lock_i   (lock_mask),
    .ptr_i    (ptr_q),
    .victim_o (victim)
  );

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RFC_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    fill_idx_q  <= fill_idx_d;
    fill_addr_q <= fill_addr_d;
  end

  // FSM next state
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    fill_idx_d  = fill_idx_q;
    fill_addr_d = fill_addr_q;
    unique case (state_q)
      RFC_IDLE: begin
        if (issue_fill) begin
          state_d     = RFC_FILL;
          fill_idx_d  = victim;
          fill_addr_d = (fill_tgt == RFC_TGT_A) ? ra_a : ra_b;
        end
      end
      RFC_FILL: begin
        state_d = RFC_IDLE;
        ptr_d   = (fill_idx_q == IdxW'(NumCacheEntries - 1)) ? '0 : fill_idx_q + 1'b1;
      end
      default: state_d = RFC_IDLE;
    endcase
  end

  // FSM outputs: the SRAM write always wins the port over a refill read
  always_comb begin
    stall_o    = 1'b0;
    sram.req   = 1'b0;
    sram.we    = 1'b0;
    sram.addr  = wa;
    sram.wdata = wdata_a_i;
    if (!rst_i) begin
      stall_o = any_miss;
      if (write_pending) begin
        sram.req = 1'b1;
        sram.we  = 1'b1;
      end else if (issue_fill) begin
        sram.req  = 1'b1;
        sram.addr = (fill_tgt == RFC_TGT_A) ? ra_a : ra_b;
      end
    end
  end

  // Entry update: write-through hits, then refill install (a same-cycle write to it wins)
  always_comb begin
    entries_d = entries_q;
    if (write_pending) begin
      for (int i = 0; i < NumCacheEntries; i++) begin
        if (wr_hit_vec[i]) entries_d[i].data = wdata_a_i;
      end
    end
    if (state_q == RFC_FILL) begin
      entries_d[fill_idx_q].valid = 1'b1;
      entries_d[fill_idx_q].tag   = fill_addr_q;
      entries_d[fill_idx_q].data  = fill_wr_hit ? wdata_a_i : sram.rdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumCacheEntries; i++) entries_q[i].valid <= 1'b0;
    end else begin
      entries_q <= entries_d;
    end
  end

  if (EnablePerfCnt) begin : g_perf
    logic [RFC_CNT_W-1:0] hit_cnt_q, miss_cnt_q;
    logic [1:0]           hit_inc;

    assign hit_inc = {1'b0, !stall_o && req_a_i && a_hit} + {1'b0, !stall_o && req_b_i && b_hit};

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        hit_cnt_q  <= '0;
        miss_cnt_q <= '0;
      end else begin
        hit_cnt_q  <= sat_add(hit_cnt_q, hit_inc);
        miss_cnt_q <= sat_add(miss_cnt_q, {1'b0, issue_fill});
      end
    end

    assign perf_hit_o  = hit_cnt_q;
    assign perf_miss_o = miss_cnt_q;
  end else begin : g_no_perf
    assign perf_hit_o  = '0;
    assign perf_miss_o = '0;
  end

endmodule
